// File: rtl/wb_bus_decoder_pkg.sv
// Shared Wishbone widths, default memory map and decoder state encoding.
// The ROM base doubles as the cpu reset PC, so both must move together.
package wb_bus_decoder_pkg;

  localparam int DAT_WIDTH = 64;
  localparam int ADR_WIDTH = 64;
  localparam int SEL_WIDTH = 8;

  // Boot ROM: 1 MiB window at the reset PC
  localparam logic [ADR_WIDTH-1:0] ROM_BASE = 64'h0000_8000_0000_0000;
  localparam logic [ADR_WIDTH-1:0] ROM_MASK = 64'hFFFF_FFFF_FFF0_0000;
  // RAM: 16 MiB at address zero
  localparam logic [ADR_WIDTH-1:0] RAM_BASE = 64'h0000_0000_0000_0000;
  localparam logic [ADR_WIDTH-1:0] RAM_MASK = 64'hFFFF_FFFF_FF00_0000;
  // IO: 64 KiB register window
  localparam logic [ADR_WIDTH-1:0] IO_BASE  = 64'h0000_4000_0000_0000;
  localparam logic [ADR_WIDTH-1:0] IO_MASK  = 64'hFFFF_FFFF_FFFF_0000;

  localparam int DEF_TIMEOUT = 16;

  // Decoder states; the encoding is visible on the debug port
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address decode for three slaves. Lower slave index wins when
// windows overlap; o_sel is one-hot (or zero together with o_no_match).
module wb_addr_match
  import wb_bus_decoder_pkg::*;
(
  input  logic [ADR_WIDTH-1:0] i_adr,
  input  logic [ADR_WIDTH-1:0] i_s0_base,
  input  logic [ADR_WIDTH-1:0] i_s0_mask,
  input  logic [ADR_WIDTH-1:0] i_s1_base,
  input  logic [ADR_WIDTH-1:0] i_s1_mask,
  input  logic [ADR_WIDTH-1:0] i_s2_base,
  input  logic [ADR_WIDTH-1:0] i_s2_mask,
  output logic [2:0]           o_sel,
  output logic                 o_no_match
);

  logic [2:0] w_hit;

  assign w_hit[0] = ((i_adr & i_s0_mask) == i_s0_base);
  assign w_hit[1] = ((i_adr & i_s1_mask) == i_s1_base);
  assign w_hit[2] = ((i_adr & i_s2_mask) == i_s2_base);

  // Priority s0 > s1 > s2 reduced to a one-hot select
  always_comb begin
    o_sel = 3'b000;
    if (w_hit[0])      o_sel = 3'b001;
    else if (w_hit[1]) o_sel = 3'b010;
    else if (w_hit[2]) o_sel = 3'b100;
  end

  assign o_no_match = ~|w_hit;

endmodule

// File: rtl/wb_bus_decoder.sv
// Wishbone shared-bus decoder between the cpu master port and ROM/RAM/IO.
//
// Handshake: the master request is valid when m_cyc_i & m_stb_i are high in
// IDLE; it is accepted on that edge (the fields are latched, the master need
// not hold them). Exactly one registered one-cycle m_ack_o or m_err_o answers
// each accepted request, except when the master drops m_cyc_i while BUSY,
// which aborts silently. On the slave side the decoder holds sN_cyc_o/sN_stb_o
// and the latched fields steady until the slave answers with sN_ack_i or
// sN_err_i (err wins), or until TIMEOUT cycles pass.
//
// Timing: request seen at edge 0 -> BUSY; slave strobe raised at edge 1;
// a slave response sampled at edge k produces m_ack_o/m_err_o after edge k.
// Every response is followed by one GAP cycle so a held strobe is never
// mistaken for a second request.
module wb_bus_decoder
  import wb_bus_decoder_pkg::*;
#(
  parameter logic [ADR_WIDTH-1:0] S0_BASE = ROM_BASE,
  parameter logic [ADR_WIDTH-1:0] S0_MASK = ROM_MASK,
  parameter logic [ADR_WIDTH-1:0] S1_BASE = RAM_BASE,
  parameter logic [ADR_WIDTH-1:0] S1_MASK = RAM_MASK,
  parameter logic [ADR_WIDTH-1:0] S2_BASE = IO_BASE,
  parameter logic [ADR_WIDTH-1:0] S2_MASK = IO_MASK,
  parameter int                   TIMEOUT = DEF_TIMEOUT
)(
  input  logic                 clk_i,
  input  logic                 rst_i,
  // master port
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [SEL_WIDTH-1:0] m_sel_i,
  input  logic [ADR_WIDTH-1:0] m_adr_i,
  input  logic [DAT_WIDTH-1:0] m_dat_i,
  output logic [DAT_WIDTH-1:0] m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  // slave 0 (boot ROM)
  output logic                 s0_cyc_o,
  output logic                 s0_stb_o,
  output logic                 s0_we_o,
  output logic [SEL_WIDTH-1:0] s0_sel_o,
  output logic [ADR_WIDTH-1:0] s0_adr_o,
  output logic [DAT_WIDTH-1:0] s0_dat_o,
  input  logic [DAT_WIDTH-1:0] s0_dat_i,
  input  logic                 s0_ack_i,
  input  logic                 s0_err_i,
  // slave 1 (RAM)
  output logic                 s1_cyc_o,
  output logic                 s1_stb_o,
  output logic                 s1_we_o,
  output logic [SEL_WIDTH-1:0] s1_sel_o,
  output logic [ADR_WIDTH-1:0] s1_adr_o,
  output logic [DAT_WIDTH-1:0] s1_dat_o,
  input  logic [DAT_WIDTH-1:0] s1_dat_i,
  input  logic                 s1_ack_i,
  input  logic                 s1_err_i,
  // slave 2 (IO)
  output logic                 s2_cyc_o,
  output logic                 s2_stb_o,
  output logic                 s2_we_o,
  output logic [SEL_WIDTH-1:0] s2_sel_o,
  output logic [ADR_WIDTH-1:0] s2_adr_o,
  output logic [DAT_WIDTH-1:0] s2_dat_o,
  input  logic [DAT_WIDTH-1:0] s2_dat_i,
  input  logic                 s2_ack_i,
  input  logic                 s2_err_i,
  // debug: current FSM state (0 IDLE, 1 BUSY, 2 GAP)
  output logic [1:0]           dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_sel_oh;   // slave chosen for the current request
  logic [2:0]             r_cyc;      // live slave strobe, one-hot or zero
  logic                   r_we;
  logic [SEL_WIDTH-1:0]   r_sel;
  logic [ADR_WIDTH-1:0]   r_adr;
  logic [DAT_WIDTH-1:0]   r_dat;
  logic [DAT_WIDTH-1:0]   r_m_dat;
  logic                   r_m_ack;
  logic                   r_m_err;

  logic [2:0]             w_sel_oh;
  logic                   w_no_match;
  logic                   w_s_ack;
  logic                   w_s_err;
  logic [DAT_WIDTH-1:0]   w_s_dat;

  wb_addr_match u_match (
    .i_adr      (m_adr_i),
    .i_s0_base  (S0_BASE),
    .i_s0_mask  (S0_MASK),
    .i_s1_base  (S1_BASE),
    .i_s1_mask  (S1_MASK),
    .i_s2_base  (S2_BASE),
    .i_s2_mask  (S2_MASK),
    .o_sel      (w_sel_oh),
    .o_no_match (w_no_match)
  );

  // Only the strobed slave's response is heard; late answers from others are dropped
  assign w_s_ack = |(r_cyc & {s2_ack_i, s1_ack_i, s0_ack_i});
  assign w_s_err = |(r_cyc & {s2_err_i, s1_err_i, s0_err_i});

  // Read-data mux follows the latched select
  always_comb begin
    w_s_dat = '0;
    unique case (1'b1)
      r_sel_oh[0]: w_s_dat = s0_dat_i;
      r_sel_oh[1]: w_s_dat = s1_dat_i;
      r_sel_oh[2]: w_s_dat = s2_dat_i;
      default:     w_s_dat = '0;
    endcase
  end

  // Decoder FSM with registered master responses and slave strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel_oh <= 3'b000;
      r_cyc    <= 3'b000;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_m_dat  <= '0;
      r_m_ack  <= 1'b0;
      r_m_err  <= 1'b0;
    end else begin
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            r_adr <= m_adr_i;
            r_sel <= m_sel_i;
            r_we  <= m_we_i;
            r_dat <= m_dat_i;
            if (w_no_match) begin
              r_m_err <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_sel_oh <= w_sel_oh;
              r_cnt    <= '0;
              r_state  <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i) begin
            // master gave up: withdraw silently
            r_cyc   <= 3'b000;
            r_state <= ST_GAP;
          end else if (r_cyc == 3'b000) begin
            // first BUSY edge launches the slave strobe
            r_cyc <= r_sel_oh;
          end else if (w_s_err) begin
            r_m_err <= 1'b1;
            r_cyc   <= 3'b000;
            r_state <= ST_GAP;
          end else if (w_s_ack) begin
            r_m_ack <= 1'b1;
            r_m_dat <= w_s_dat;
            r_cyc   <= 3'b000;
            r_state <= ST_GAP;
          end else if (r_cnt == CNT_LAST) begin
            r_m_err <= 1'b1;
            r_cyc   <= 3'b000;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_cyc   <= 3'b000;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_dat_o     = r_m_dat;
  assign m_ack_o     = r_m_ack;
  assign m_err_o     = r_m_err;
  assign dbg_state_o = r_state;

  assign s0_cyc_o = r_cyc[0];
  assign s0_stb_o = r_cyc[0];
  assign s0_we_o  = r_we & r_cyc[0];
  assign s0_sel_o = r_sel;
  assign s0_adr_o = r_adr;
  assign s0_dat_o = r_dat;

  assign s1_cyc_o = r_cyc[1];
  assign s1_stb_o = r_cyc[1];
  assign s1_we_o  = r_we & r_cyc[1];
  assign s1_sel_o = r_sel;
  assign s1_adr_o = r_adr;
  assign s1_dat_o = r_dat;

  assign s2_cyc_o = r_cyc[2];
  assign s2_stb_o = r_cyc[2];
  assign s2_we_o  = r_we & r_cyc[2];
  assign s2_sel_o = r_sel;
  assign s2_adr_o = r_adr;
  assign s2_dat_o = r_dat;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder: inputs driven and outputs sampled on the
// falling clock edge; expected read data held in a queue.
module tb_wb_bus_decoder;
  import wb_bus_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic                 m_cyc, m_stb, m_we;
  logic [SEL_WIDTH-1:0] m_sel;
  logic [ADR_WIDTH-1:0] m_adr;
  logic [DAT_WIDTH-1:0] m_dat_w;
  logic [DAT_WIDTH-1:0] m_dat_r;
  logic                 m_ack, m_err;

  logic                 s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we, s2_cyc, s2_stb, s2_we;
  logic [SEL_WIDTH-1:0] s0_sel, s1_sel, s2_sel;
  logic [ADR_WIDTH-1:0] s0_adr, s1_adr, s2_adr;
  logic [DAT_WIDTH-1:0] s0_dat_o, s1_dat_o, s2_dat_o;
  logic [DAT_WIDTH-1:0] s0_dat_i, s1_dat_i, s2_dat_i;
  logic                 s0_ack, s0_err, s1_ack, s1_err, s2_ack, s2_err;
  logic [1:0]           dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DAT_WIDTH-1:0] exp_q[$];
  logic [DAT_WIDTH-1:0] exp_d;

  wb_bus_decoder dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_dat_o(m_dat_r),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s0_cyc_o(s0_cyc), .s0_stb_o(s0_stb), .s0_we_o(s0_we), .s0_sel_o(s0_sel),
    .s0_adr_o(s0_adr), .s0_dat_o(s0_dat_o), .s0_dat_i(s0_dat_i),
    .s0_ack_i(s0_ack), .s0_err_i(s0_err),
    .s1_cyc_o(s1_cyc), .s1_stb_o(s1_stb), .s1_we_o(s1_we), .s1_sel_o(s1_sel),
    .s1_adr_o(s1_adr), .s1_dat_o(s1_dat_o), .s1_dat_i(s1_dat_i),
    .s1_ack_i(s1_ack), .s1_err_i(s1_err),
    .s2_cyc_o(s2_cyc), .s2_stb_o(s2_stb), .s2_we_o(s2_we), .s2_sel_o(s2_sel),
    .s2_adr_o(s2_adr), .s2_dat_o(s2_dat_o), .s2_dat_i(s2_dat_i),
    .s2_ack_i(s2_ack), .s2_err_i(s2_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_req(input logic we, input logic [63:0] adr,
                           input logic [63:0] dat, input logic [7:0] sel);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = dat; m_sel = sel;
  endtask

  task automatic end_req();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    s0_ack = 0; s0_err = 0; s0_dat_i = '0;
    s1_ack = 0; s1_err = 0; s1_dat_i = '0;
    s2_ack = 0; s2_err = 0; s2_dat_i = '0;
    tick(); tick();
    total++; if ({m_ack, m_err} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", {m_ack, m_err}); end
    total++; if (m_dat_r !== 64'h0) begin bad++; $display("FAIL reset_mdat got=%h exp=0", m_dat_r); end
    total++; if ({s0_cyc, s1_cyc, s2_cyc, s0_stb, s1_stb, s2_stb} !== 6'b0) begin bad++; $display("FAIL reset_scyc got=%b exp=0", {s0_cyc, s1_cyc, s2_cyc, s0_stb, s1_stb, s2_stb}); end
    total++; if ({s0_adr, s1_dat_o, s2_sel} !== '0) begin bad++; $display("FAIL reset_sfields got=%h exp=0", {s0_adr, s1_dat_o, s2_sel}); end
    rst_i = 1'b1;
    tick();
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_rom_read();
    start_req(1'b0, 64'h0000_8000_0000_0000, 64'h0, 8'hFF);
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    tick(); // request accepted
    total++; if (dbg_state !== 2'd1 || s0_cyc !== 1'b0) begin bad++; $display("FAIL rom_accept got=%0d/%b exp=1/0", dbg_state, s0_cyc); end
    tick(); // strobe raised
    total++; if ({s0_cyc, s0_stb, s0_we} !== 3'b110) begin bad++; $display("FAIL rom_stb got=%b exp=110", {s0_cyc, s0_stb, s0_we}); end
    total++; if (s0_adr !== 64'h0000_8000_0000_0000) begin bad++; $display("FAIL rom_adr got=%h exp=800000000000", s0_adr); end
    total++; if ({s1_cyc, s2_cyc} !== 2'b00) begin bad++; $display("FAIL rom_others got=%b exp=00", {s1_cyc, s2_cyc}); end
    tick(); // slave answers one cycle after its strobe
    s0_ack = 1'b1; s0_dat_i = 64'hDEADBEEF_CAFEF00D;
    tick();
    exp_d = exp_q.pop_front();
    total++; if ({m_ack, m_err} !== 2'b10) begin bad++; $display("FAIL rom_ack got=%b exp=10", {m_ack, m_err}); end
    total++; if (m_dat_r !== exp_d) begin bad++; $display("FAIL rom_data got=%h exp=%h", m_dat_r, exp_d); end
    total++; if (s0_cyc !== 1'b0 || dbg_state !== 2'd2) begin bad++; $display("FAIL rom_release got=%b/%0d exp=0/2", s0_cyc, dbg_state); end
    s0_ack = 1'b0; end_req();
    tick();
    total++; if (m_ack !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rom_one_pulse got=%b/%0d exp=0/0", m_ack, dbg_state); end
    total++; if (m_dat_r !== exp_d) begin bad++; $display("FAIL rom_hold got=%h exp=%h", m_dat_r, exp_d); end
  endtask

  task automatic test_ram_write();
    start_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF);
    exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F0);
    tick(); tick();
    total++; if ({s1_cyc, s1_stb, s1_we} !== 3'b111) begin bad++; $display("FAIL ram_stb got=%b exp=111", {s1_cyc, s1_stb, s1_we}); end
    total++; if (s1_adr !== 64'h10 || s1_dat_o !== 64'h1122334455667788 || s1_sel !== 8'hFF) begin bad++; $display("FAIL ram_fields got=%h/%h/%h", s1_adr, s1_dat_o, s1_sel); end
    total++; if ({s0_cyc, s2_cyc} !== 2'b00) begin bad++; $display("FAIL ram_others got=%b exp=00", {s0_cyc, s2_cyc}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (s1_cyc !== 1'b1 || m_ack !== 1'b0) begin bad++; $display("FAIL ram_wait%0d got=%b/%b exp=1/0", i, s1_cyc, m_ack); end
    end
    s1_ack = 1'b1; s1_dat_i = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
    exp_d = exp_q.pop_front();
    total++; if (m_ack !== 1'b1 || m_dat_r !== exp_d) begin bad++; $display("FAIL ram_ack got=%b/%h exp=1/%h", m_ack, m_dat_r, exp_d); end
    total++; if (dbg_state !== 2'd2 || s1_cyc !== 1'b0) begin bad++; $display("FAIL ram_gap got=%0d/%b exp=2/0", dbg_state, s1_cyc); end
    s1_ack = 1'b0; end_req();
    tick();
    total++; if (dbg_state !== 2'd0 || m_ack !== 1'b0) begin bad++; $display("FAIL ram_idle got=%0d/%b exp=0/0", dbg_state, m_ack); end
  endtask

  task automatic test_unmapped();
    logic [63:0] adrs [2];
    adrs[0] = 64'h0000_2000_0000_0000;
    adrs[1] = 64'h0000_8000_0010_0000; // first byte past the ROM window
    for (int i = 0; i < 2; i++) begin
      start_req(1'b0, adrs[i], 64'h0, 8'hFF);
      tick();
      total++; if ({m_ack, m_err} !== 2'b01) begin bad++; $display("FAIL unmapped%0d_err got=%b exp=01", i, {m_ack, m_err}); end
      total++; if ({s0_cyc, s1_cyc, s2_cyc} !== 3'b000 || dbg_state !== 2'd2) begin bad++; $display("FAIL unmapped%0d_scyc got=%b/%0d exp=000/2", i, {s0_cyc, s1_cyc, s2_cyc}, dbg_state); end
      end_req();
      tick();
      total++; if (m_err !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL unmapped%0d_clear got=%b/%0d exp=0/0", i, m_err, dbg_state); end
    end
  endtask

  task automatic test_timeout();
    start_req(1'b0, 64'h0000_4000_0000_0008, 64'h0, 8'h0F);
    tick(); tick();
    total++; if (s2_stb !== 1'b1) begin bad++; $display("FAIL tmo_stb got=%b exp=1", s2_stb); end
    for (int i = 0; i < 15; i++) begin
      tick();
      total++; if (s2_stb !== 1'b1 || m_err !== 1'b0) begin bad++; $display("FAIL tmo_hold%0d got=%b/%b exp=1/0", i, s2_stb, m_err); end
    end
    tick();
    total++; if (s2_stb !== 1'b0 || {m_ack, m_err} !== 2'b01) begin bad++; $display("FAIL tmo_abort got=%b/%b exp=0/01", s2_stb, {m_ack, m_err}); end
    s2_ack = 1'b1; s2_dat_i = 64'h5555; end_req();
    tick();
    total++; if ({m_ack, m_err} !== 2'b00) begin bad++; $display("FAIL tmo_late_gap got=%b exp=00", {m_ack, m_err}); end
    tick();
    total++; if ({m_ack, m_err} !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL tmo_late_idle got=%b/%0d exp=00/0", {m_ack, m_err}, dbg_state); end
    s2_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    // top word of the RAM window; master holds its strobe through GAP
    start_req(1'b0, 64'h0000_0000_00FF_FFF8, 64'h0, 8'hFF);
    tick(); tick();
    total++; if (s1_cyc !== 1'b1) begin bad++; $display("FAIL b2b_stb got=%b exp=1", s1_cyc); end
    s1_ack = 1'b1; s1_err = 1'b1;
    tick();
    total++; if ({m_ack, m_err} !== 2'b01 || s1_cyc !== 1'b0) begin bad++; $display("FAIL b2b_errwins got=%b/%b exp=01/0", {m_ack, m_err}, s1_cyc); end
    s1_ack = 1'b0; s1_err = 1'b0;
    tick();
    total++; if ({m_ack, m_err} !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL b2b_gap got=%b/%0d exp=00/0", {m_ack, m_err}, dbg_state); end
    tick();
    total++; if (dbg_state !== 2'd1 || s1_cyc !== 1'b0) begin bad++; $display("FAIL b2b_second got=%0d/%b exp=1/0", dbg_state, s1_cyc); end
    tick();
    total++; if (s1_cyc !== 1'b1) begin bad++; $display("FAIL b2b_stb2 got=%b exp=1", s1_cyc); end
    s1_ack = 1'b1; s1_dat_i = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    tick();
    exp_d = exp_q.pop_front();
    total++; if ({m_ack, m_err} !== 2'b10 || m_dat_r !== exp_d) begin bad++; $display("FAIL b2b_ack2 got=%b/%h exp=10/%h", {m_ack, m_err}, m_dat_r, exp_d); end
    s1_ack = 1'b0; end_req();
    tick();
    total++; if (m_ack !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", m_ack); end
  endtask

  task automatic test_abort();
    start_req(1'b1, 64'h0000_4000_0000_0100, 64'h77, 8'h01);
    tick(); tick();
    total++; if ({s2_cyc, s2_we} !== 2'b11) begin bad++; $display("FAIL abort_stb got=%b exp=11", {s2_cyc, s2_we}); end
    end_req();
    tick();
    total++; if (s2_cyc !== 1'b0 || {m_ack, m_err} !== 2'b00 || dbg_state !== 2'd2) begin bad++; $display("FAIL abort_drop got=%b/%b/%0d exp=0/00/2", s2_cyc, {m_ack, m_err}, dbg_state); end
    tick();
    total++; if ({m_ack, m_err} !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL abort_idle got=%b/%0d exp=00/0", {m_ack, m_err}, dbg_state); end
  endtask

  task automatic test_reset_mid_busy();
    start_req(1'b0, 64'h0000_8000_0000_0040, 64'h0, 8'hFF);
    tick(); tick();
    total++; if (s0_cyc !== 1'b1) begin bad++; $display("FAIL rstb_stb got=%b exp=1", s0_cyc); end
    #2 rst_i = 1'b0;
    #1;
    total++; if ({s0_cyc, s0_stb, m_ack, m_err} !== 4'b0) begin bad++; $display("FAIL rstb_ctrl got=%b exp=0", {s0_cyc, s0_stb, m_ack, m_err}); end
    total++; if (m_dat_r !== 64'h0 || s0_adr !== 64'h0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rstb_data got=%h/%h/%0d exp=0", m_dat_r, s0_adr, dbg_state); end
    end_req();
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    start_req(1'b0, 64'h0000_0000_0000_0040, 64'h0, 8'hFF);
    tick(); tick();
    total++; if ({s0_cyc, s1_cyc, s2_cyc} !== 3'b010) begin bad++; $display("FAIL rstb_new_stb got=%b exp=010", {s0_cyc, s1_cyc, s2_cyc}); end
    s1_ack = 1'b1; s1_dat_i = 64'h0000_0000_0000_FEED;
    exp_q.push_back(64'h0000_0000_0000_FEED);
    tick();
    exp_d = exp_q.pop_front();
    total++; if (m_ack !== 1'b1 || m_dat_r !== exp_d) begin bad++; $display("FAIL rstb_new_ack got=%b/%h exp=1/%h", m_ack, m_dat_r, exp_d); end
    s1_ack = 1'b0; end_req();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rom_read();
    test_ram_write();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
